regfile_test_driver: RTL and testbench



---
 rtl/regfile_test_driver_if.sv | 24 ++
 rtl/regfile_test_driver.sv | 177 +++++++++++++++++
 tb/tb_regfile_test_driver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_test_driver_if.sv
// Regfile test port bundle: write controls, both read addresses, the read data
// that comes back, and the mux select that hands the regfile to the driver.
interface regfile_test_driver_if;
    logic        test;
    logic        t_ctrl_writeEnable;
    logic [4:0]  t_ctrl_writeReg;
    logic [4:0]  t_ctrl_readRegA;
    logic [4:0]  t_ctrl_readRegB;
    logic [31:0] t_data_writeReg;
    logic [31:0] t_data_readRegA;
    logic [31:0] t_data_readRegB;

    modport master (
        output test, t_ctrl_writeEnable, t_ctrl_writeReg,
        output t_ctrl_readRegA, t_ctrl_readRegB, t_data_writeReg,
        input  t_data_readRegA, t_data_readRegB
    );

    modport slave (
        input  test, t_ctrl_writeEnable, t_ctrl_writeReg,
        input  t_ctrl_readRegA, t_ctrl_readRegB, t_data_writeReg,
        output t_data_readRegA, t_data_readRegB
    );
endinterface

// File: rtl/regfile_test_driver.sv
// Regfile bring-up sequencer: writes a pattern to r0..r31, reads it back on both ports, counts mismatches.
// Optional first-mismatch capture outputs are enabled by defining REGFILE_TEST_ERRLOG_EN.
module regfile_test_driver #(
    parameter logic [31:0] SEED     = 32'hA5A5_0000,
    parameter int          READ_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    regfile_test_driver_if.master rf,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [5:0]            err_count
`ifdef REGFILE_TEST_ERRLOG_EN
    ,
    output logic                  fail_valid,
    output logic [4:0]            fail_reg,
    output logic [31:0]           fail_data
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE} state_t;

    localparam logic [1:0] SLOT_LAST = 2'(READ_LAT);

    state_t      r_state, w_state_next;
    logic [4:0]  r_idx, w_idx_next;
    logic [1:0]  r_slot, w_slot_next;
    logic [5:0]  r_err;
    logic        r_done, r_pass;

    logic        w_start_take, w_slot_last, w_miss_a, w_miss_b;
    logic [4:0]  w_idx_b;
    logic [31:0] w_exp_a, w_exp_b;
    logic [6:0]  w_err_sum;
    logic [5:0]  w_err_next;

    function automatic logic [31:0] pattern(input logic [4:0] i);
        return SEED + ({27'd0, i} * 32'h0101_0101);
    endfunction

    // r0 is hardwired to zero, so it must read back 0 despite being written
    function automatic logic [31:0] expected(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : pattern(i);
    endfunction

    assign w_start_take = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_slot_last  = (r_slot == SLOT_LAST);
    assign w_idx_b      = 5'd31 - r_idx;
    assign w_exp_a      = expected(r_idx);
    assign w_exp_b      = expected(w_idx_b);
    assign w_miss_a     = (r_state == S_READ) && w_slot_last && (rf.t_data_readRegA != w_exp_a);
    assign w_miss_b     = (r_state == S_READ) && w_slot_last && (rf.t_data_readRegB != w_exp_b);
    assign w_err_sum    = {1'b0, r_err} + {6'd0, w_miss_a} + {6'd0, w_miss_b};
    assign w_err_next   = (w_err_sum > 7'd63) ? 6'd63 : w_err_sum[5:0];

    always_comb begin
        w_state_next          = r_state;
        w_idx_next            = r_idx;
        w_slot_next           = r_slot;
        busy                  = 1'b0;
        rf.test               = 1'b0;
        rf.t_ctrl_writeEnable = 1'b0;
        rf.t_ctrl_writeReg    = 5'd0;
        rf.t_ctrl_readRegA    = 5'd0;
        rf.t_ctrl_readRegB    = 5'd0;
        rf.t_data_writeReg    = 32'd0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_WRITE;
                    w_idx_next   = 5'd0;
                    w_slot_next  = 2'd0;
                end
            end
            S_WRITE: begin
                busy                  = 1'b1;
                rf.test               = 1'b1;
                rf.t_ctrl_writeEnable = 1'b1;
                rf.t_ctrl_writeReg    = r_idx;
                rf.t_data_writeReg    = pattern(r_idx);
                w_idx_next            = r_idx + 5'd1;
                if (r_idx == 5'd31) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                // keeps the r31 write from colliding with the first reads
                busy         = 1'b1;
                rf.test      = 1'b1;
                w_state_next = S_READ;
                w_idx_next   = 5'd0;
                w_slot_next  = 2'd0;
            end
            S_READ: begin
                busy               = 1'b1;
                rf.test            = 1'b1;
                rf.t_ctrl_readRegA = r_idx;
                rf.t_ctrl_readRegB = w_idx_b;
                if (w_slot_last) begin
                    w_slot_next = 2'd0;
                    w_idx_next  = r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        w_state_next = S_DONE;
                    end
                end else begin
                    w_slot_next = r_slot + 2'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_slot  <= 2'd0;
            r_err   <= 6'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_slot  <= w_slot_next;
            if (w_start_take) begin
                r_err  <= 6'd0;
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end else begin
                r_err <= w_err_next;
                // result is published one cycle after the last compare has landed
                if (r_state == S_DONE) begin
                    r_done <= 1'b1;
                    r_pass <= (r_err == 6'd0);
                end
            end
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

`ifdef REGFILE_TEST_ERRLOG_EN
    logic        r_fail_valid;
    logic [4:0]  r_fail_reg;
    logic [31:0] r_fail_data;

    // port A wins when both ports miss in the same slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fail_valid <= 1'b0;
            r_fail_reg   <= 5'd0;
            r_fail_data  <= 32'd0;
        end else if (w_start_take) begin
            r_fail_valid <= 1'b0;
            r_fail_reg   <= 5'd0;
            r_fail_data  <= 32'd0;
        end else if (!r_fail_valid && w_miss_a) begin
            r_fail_valid <= 1'b1;
            r_fail_reg   <= r_idx;
            r_fail_data  <= rf.t_data_readRegA;
        end else if (!r_fail_valid && w_miss_b) begin
            r_fail_valid <= 1'b1;
            r_fail_reg   <= w_idx_b;
            r_fail_data  <= rf.t_data_readRegB;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_reg   = r_fail_reg;
    assign fail_data  = r_fail_data;
`endif
endmodule

// File: tb/tb_regfile_test_driver.sv
// Bench for regfile_test_driver: a faultable regfile model feeds the driver, and
// expected results come from scanning the model's contents against the pattern rules.
module tb_regfile_test_driver;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [5:0]  err_count;
`ifdef REGFILE_TEST_ERRLOG_EN
    logic        fail_valid;
    logic [4:0]  fail_reg;
    logic [31:0] fail_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regfile_test_driver_if rf();

    regfile_test_driver dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rf        (rf),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
`ifdef REGFILE_TEST_ERRLOG_EN
        ,
        .fail_valid(fail_valid),
        .fail_reg  (fail_reg),
        .fail_data (fail_data)
`endif
    );

    // fault modes: 0 ideal, 1 one stuck register, 2 writable r0, 3 reads all zero
    logic [1:0]  fault_mode = 2'd0;
    logic [4:0]  stuck_reg  = 5'd0;
    logic [31:0] stuck_val  = 32'd0;
    logic [31:0] mem  [32];
    logic [31:0] view [32];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end

    always @(posedge clock) begin
        if (rf.test && rf.t_ctrl_writeEnable) mem[rf.t_ctrl_writeReg] <= rf.t_data_writeReg;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            view[i] = (i == 0 && fault_mode != 2'd2) ? 32'd0 : mem[i];
            if (fault_mode == 2'd1 && 5'(i) == stuck_reg) view[i] = stuck_val;
            if (fault_mode == 2'd3) view[i] = 32'd0;
        end
    end

    assign rf.t_data_readRegA = view[rf.t_ctrl_readRegA];
    assign rf.t_data_readRegB = view[rf.t_ctrl_readRegB];

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] expv(input int i);
        return (i == 0) ? 32'd0 : pat(i);
    endfunction

    // what a faulty regfile holds after a full write pass
    function automatic logic [31:0] contents(input int i);
        case (fault_mode)
            2'd1:    return (5'(i) == stuck_reg) ? stuck_val : expv(i);
            2'd2:    return pat(i);
            2'd3:    return 32'd0;
            default: return expv(i);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_run(input string tag);
        int          cyc;
        int          n_err;
        logic [5:0]  exp_err;
        logic        found;
        logic [4:0]  exp_freg;
        logic [31:0] exp_fdata;
        n_err = 0;
        found = 1'b0;
        exp_freg = 5'd0;
        exp_fdata = 32'd0;
        for (int s = 0; s < 32; s++) begin
            if (contents(s) != expv(s)) begin
                n_err++;
                if (!found) begin found = 1'b1; exp_freg = 5'(s); exp_fdata = contents(s); end
            end
            if (contents(31 - s) != expv(31 - s)) begin
                n_err++;
                if (!found) begin found = 1'b1; exp_freg = 5'(31 - s); exp_fdata = contents(31 - s); end
            end
        end
        exp_err = (n_err > 63) ? 6'd63 : 6'(n_err);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("write_phase", {rf.test, busy, rf.t_ctrl_writeEnable, rf.t_ctrl_writeReg, rf.t_data_writeReg},
                {1'b1, 1'b1, 1'b1, 5'(k), pat(k)});
            if (k == 1)  chk("write_data_r1", rf.t_data_writeReg, 32'hA6A6_0101);
            if (k == 31) chk("write_data_r31", rf.t_data_writeReg, 32'hC4C4_1F1F);
            step();
        end
        chk("gap", {rf.test, busy, rf.t_ctrl_writeEnable, done}, 4'b1100);
        cyc = 32;
        while (done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        chk("done_latency", cyc, 98);
        chk("done_outputs", {rf.test, busy, rf.t_ctrl_writeEnable, rf.t_ctrl_readRegA, rf.t_data_writeReg}, 0);
        chk("err_count", err_count, exp_err);
        chk("pass", pass, (exp_err == 6'd0));
`ifdef REGFILE_TEST_ERRLOG_EN
        chk("fail_valid", fail_valid, found);
        chk("fail_reg", fail_reg, exp_freg);
        chk("fail_data", fail_data, exp_fdata);
`endif
        repeat (3) step();
        chk("done_held", {done, pass, err_count}, {1'b1, (exp_err == 6'd0), exp_err});
        $display("run %s: mode=%0d done_cycle=%0d err_count=%0d (exp %0d) pass=%0b",
                 tag, fault_mode, cyc, err_count, exp_err, pass);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        repeat (2) step();
        chk("reset_ctrl", {rf.test, busy, rf.t_ctrl_writeEnable, rf.t_ctrl_writeReg,
                           rf.t_ctrl_readRegA, rf.t_ctrl_readRegB}, 0);
        chk("reset_data", rf.t_data_writeReg, 32'd0);
        chk("reset_status", {done, pass, err_count}, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("idle_no_start", {busy, rf.test, done}, 0);

        fault_mode = 2'd0;
        do_run("ideal");

        fault_mode = 2'd1; stuck_reg = 5'd5; stuck_val = 32'd0;
        do_run("r5_stuck0");

        for (int r = 0; r < 3; r++) begin
            fault_mode = 2'd1;
            stuck_reg  = 5'($urandom_range(1, 31));
            stuck_val  = (r == 2) ? pat(int'(stuck_reg)) : $urandom;
            do_run("random_stuck");
        end

        fault_mode = 2'd2;
        do_run("writable_r0");

        fault_mode = 2'd3;
        do_run("all_zero");

        // reset in the middle of READ slot 10
        fault_mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (54) step();
        chk("slot10_addr", {rf.t_ctrl_readRegA, rf.t_ctrl_readRegB}, {5'd10, 5'd21});
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_ctrl", {rf.test, busy, rf.t_ctrl_writeEnable, rf.t_ctrl_readRegA}, 0);
        chk("async_reset_status", {done, pass, err_count}, 0);
        $display("run reset_mid_read: test=%0b busy=%0b we=%0b", rf.test, busy, rf.t_ctrl_writeEnable);
        repeat (2) step();
        @(negedge clock);
        reset = 1'b1;
        step();
        do_run("after_reset");

        // start held through the whole run
        fault_mode = 2'd3;
        start = 1'b1;
        step();
        cyc = 0;
        while (busy === 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        chk("held_start_no_restart", cyc, 97);
        chk("held_start_errs", err_count, 6'd62);
        step();
        chk("held_start_rewrite", {busy, rf.t_ctrl_writeEnable, rf.t_ctrl_writeReg}, {1'b1, 1'b1, 5'd0});
        chk("held_start_err_clear", {err_count, done}, 0);
        $display("run held_start: busy_cycles=%0d err_count_after_restart=%0d", cyc, err_count);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        chk("held_start_second_done", {done, err_count}, {1'b1, 6'd62});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
